// File: rtl/ahb_req_master_if.sv
// Signal bundle for ahb_req_master: the req/gnt load-store side plus the AHB3-Lite master side.
// The master modport is the bridge's own view; the slave modport is the environment around it.
interface ahb_req_master_if;
    // load-store request side
    logic        req_i;
    logic [31:0] req_addr_i;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_wdata_i;
    logic        gnt_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    // AHB3-Lite master side
    logic [31:0] m_haddr_o;
    logic        m_hwrite_o;
    logic [2:0]  m_hsize_o;
    logic [1:0]  m_htrans_o;
    logic [2:0]  m_hburst_o;
    logic        m_hmastlock_o;
    logic [3:0]  m_hprot_o;
    logic [31:0] m_hwdata_o;
    logic [5:0]  m_hparity_o;
    logic [6:0]  m_hwchecksum_o;
    logic [31:0] m_hrdata_i;
    logic [6:0]  m_hrchecksum_i;
    logic        m_hready_i;
    logic        m_hresp_i;

    modport master (
        input  req_i, req_addr_i, req_we_i, req_size_i, req_wdata_i,
        output gnt_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output m_haddr_o, m_hwrite_o, m_hsize_o, m_htrans_o, m_hburst_o,
        output m_hmastlock_o, m_hprot_o, m_hwdata_o, m_hparity_o, m_hwchecksum_o,
        input  m_hrdata_i, m_hrchecksum_i, m_hready_i, m_hresp_i
    );

    modport slave (
        output req_i, req_addr_i, req_we_i, req_size_i, req_wdata_i,
        input  gnt_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  m_haddr_o, m_hwrite_o, m_hsize_o, m_htrans_o, m_hburst_o,
        input  m_hmastlock_o, m_hprot_o, m_hwdata_o, m_hparity_o, m_hwchecksum_o,
        output m_hrdata_i, m_hrchecksum_i, m_hready_i, m_hresp_i
    );
endinterface

// File: rtl/ahb_req_master.sv
// req/gnt to AHB3-Lite single-transfer master with two-slot pipeline and ERROR retry.
// Optional `AHB_PROTECTION_EN adds address/control parity, write checksum and read-checksum checking.
module ahb_req_master #(
    parameter int         MAX_RETRY = 2,
    parameter logic [3:0] HPROT     = 4'b0011
) (
    input  logic                  s_clk_i,
    input  logic                  s_resetn_i,
    ahb_req_master_if.master      bus
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] LP_MAX_RETRY  = 3'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ERR   = 2'd1,
        ST_RETRY = 2'd2
    } state_t;

    typedef struct packed {
        logic        v;
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    state_t      r_state;
    xfer_t       r_ap;
    xfer_t       r_dp;
    logic [2:0]  r_retry_cnt;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic        w_run;
    logic        w_retry;
    logic        w_cks_err;
    logic        w_bus_err;
    logic        w_adv;
    logic        w_gnt;
    logic        w_err_final;
    xfer_t       w_aphase;
    logic [31:0] w_haddr;
    logic        w_hwrite;
    logic [2:0]  w_hsize;
    logic [1:0]  w_htrans;
    logic [5:0]  w_parity;
    logic [6:0]  w_wchecksum;

`ifdef AHB_PROTECTION_EN
    // Bit i<6 covers data bits j whose (j+1) has bit i set; bit 6 is plain parity.
    function automatic logic [6:0] f_checksum(input logic [31:0] d);
        logic [6:0] c;
        logic [5:0] idx;
        c = '0;
        for (int j = 0; j < 32; j++) begin
            idx = 6'(j + 1);
            for (int i = 0; i < 6; i++) begin
                if (idx[i]) c[i] = c[i] ^ d[j];
            end
        end
        c[6] = ^d;
        return c;
    endfunction

    // A bad word-read checksum only counts once the slave signals the data is valid.
    assign w_cks_err = w_run && r_dp.v && !r_dp.we && (r_dp.size == 2'd2) &&
                       bus.m_hready_i && !bus.m_hresp_i &&
                       (f_checksum(bus.m_hrdata_i) != bus.m_hrchecksum_i);
`else
    logic w_unused_hrchecksum;
    assign w_unused_hrchecksum = ^bus.m_hrchecksum_i;
    assign w_cks_err           = 1'b0;
`endif

    assign w_run     = (r_state == ST_RUN);
    assign w_retry   = (r_state == ST_RETRY);
    assign w_bus_err = bus.m_hresp_i | w_cks_err;
    assign w_adv     = w_run & bus.m_hready_i & ~w_bus_err;

    // Grants are held off for the whole error episode and while reset is asserted.
    assign w_gnt = s_resetn_i & bus.req_i & w_run & ~w_bus_err & (~r_ap.v | bus.m_hready_i);

    // Second ERROR cycle, or a checksum failure on the completing data phase.
    assign w_err_final = ((r_state == ST_ERR) & bus.m_hready_i) | w_cks_err;

    // During RETRY the failed data-phase transfer is driven back onto the address bus.
    assign w_aphase = w_retry ? r_dp : r_ap;
    assign w_haddr  = w_aphase.addr;
    assign w_hwrite = w_aphase.we;
    assign w_hsize  = {1'b0, w_aphase.size};
    assign w_htrans = ((w_run & r_ap.v & ~w_bus_err) | w_retry) ? HTRANS_NONSEQ : HTRANS_IDLE;

`ifdef AHB_PROTECTION_EN
    assign w_parity[0] = ^w_haddr[7:0];
    assign w_parity[1] = ^w_haddr[15:8];
    assign w_parity[2] = ^w_haddr[23:16];
    assign w_parity[3] = ^w_haddr[31:24];
    assign w_parity[4] = ^{w_hsize, 3'b000, HPROT, w_hwrite, 1'b0};
    assign w_parity[5] = ^w_htrans;
    assign w_wchecksum = f_checksum(r_dp.wdata);
`else
    assign w_parity    = '0;
    assign w_wchecksum = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            r_state     <= ST_RUN;
            r_ap        <= '0;
            r_dp        <= '0;
            r_retry_cnt <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;

            if (w_err_final) begin
                if (r_retry_cnt < LP_MAX_RETRY) begin
                    r_state     <= ST_RETRY;
                    r_retry_cnt <= r_retry_cnt + 3'd1;
                end else begin
                    r_state     <= ST_RUN;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b1;
                    r_dp.v      <= 1'b0;
                    r_retry_cnt <= '0;
                end
            end else begin
                unique case (r_state)
                    ST_RUN: begin
                        if (w_adv) begin
                            if (r_dp.v) begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_rdata <= r_dp.we ? 32'h0 : bus.m_hrdata_i;
                                r_retry_cnt <= '0;
                            end
                            r_dp <= r_ap;
                        end else if (bus.m_hresp_i && !bus.m_hready_i && r_dp.v) begin
                            r_state <= ST_ERR;
                        end
                    end
                    ST_ERR:   r_state <= ST_ERR;
                    ST_RETRY: if (bus.m_hready_i) r_state <= ST_RUN;
                    default:  r_state <= ST_RUN;
                endcase
            end

            if (w_gnt) begin
                r_ap <= '{v: 1'b1, addr: bus.req_addr_i, we: bus.req_we_i,
                          size: bus.req_size_i, wdata: bus.req_wdata_i};
            end else if (w_adv) begin
                r_ap.v <= 1'b0;
            end
        end
    end

    assign bus.gnt_o          = w_gnt;
    assign bus.rsp_valid_o    = r_rsp_valid;
    assign bus.rsp_rdata_o    = r_rsp_rdata;
    assign bus.rsp_err_o      = r_rsp_err;
    assign bus.m_haddr_o      = w_haddr;
    assign bus.m_hwrite_o     = w_hwrite;
    assign bus.m_hsize_o      = w_hsize;
    assign bus.m_htrans_o     = w_htrans;
    assign bus.m_hburst_o     = 3'b000;
    assign bus.m_hmastlock_o  = 1'b0;
    assign bus.m_hprot_o      = HPROT;
    assign bus.m_hwdata_o     = r_dp.wdata;
    assign bus.m_hparity_o    = w_parity;
    assign bus.m_hwchecksum_o = w_wchecksum;

endmodule

// File: tb/tb_ahb_req_master.sv
// Directed bench for ahb_req_master: pipelining, wait states, ERROR retry, protection, reset.
// Works with or without AHB_PROTECTION_EN defined.
module tb_ahb_req_master;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] NSQ  = 2'b10;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    int   rsp_cnt = 0;

    ahb_req_master_if bus();

    ahb_req_master #(.MAX_RETRY(2), .HPROT(4'b0011)) dut (
        .s_clk_i    (clk),
        .s_resetn_i (rstn),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] cks(input logic [31:0] d);
        logic [6:0] c;
        c = '0;
        for (int j = 0; j < 32; j++)
            for (int i = 0; i < 6; i++)
                if ((((j + 1) >> i) % 2) == 1) c[i] = c[i] ^ d[j];
        c[6] = ^d;
        return c;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
        bus.req_i       = v;
        bus.req_we_i    = we;
        bus.req_size_i  = sz;
        bus.req_addr_i  = a;
        bus.req_wdata_i = d;
    endtask

    task automatic slv(input logic rdy, input logic rsp, input logic [31:0] rd);
        bus.m_hready_i     = rdy;
        bus.m_hresp_i      = rsp;
        bus.m_hrdata_i     = rd;
        bus.m_hrchecksum_i = cks(rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req(1, 0, 2, 32'h0, 32'h0);
        slv(1, 0, 32'h0);
        #2 rstn = 1'b0;
        #10;
        check("rst gnt",      bus.gnt_o, 0);
        check("rst htrans",   bus.m_htrans_o, IDLE);
        check("rst rsp",      bus.rsp_valid_o, 0);
        check("rst err",      bus.rsp_err_o, 0);
        check("rst haddr",    bus.m_haddr_o, 0);
        check("rst hwdata",   bus.m_hwdata_o, 0);
        check("rst parity",   bus.m_hparity_o, 0);
        check("rst wcks",     bus.m_hwchecksum_o, 0);
        check("rst hprot",    bus.m_hprot_o, 4'b0011);
        check("rst hburst",   bus.m_hburst_o, 0);
        check("rst hlock",    bus.m_hmastlock_o, 0);
        req(0, 0, 0, 32'h0, 32'h0);
        @(negedge clk) rstn = 1'b1;

        // 1: single word read, zero wait states
        cyc(); req(1, 0, 2, 32'h100, 0); #1;
        check("t1 gnt", bus.gnt_o, 1);
        check("t1 idle", bus.m_htrans_o, IDLE);
        cyc(); req(0, 0, 0, 0, 0); #1;
        check("t1 nonseq", bus.m_htrans_o, NSQ);
        check("t1 haddr", bus.m_haddr_o, 32'h100);
        check("t1 hsize", bus.m_hsize_o, 3'd2);
        check("t1 hwrite", bus.m_hwrite_o, 0);
        check("t1 gnt low", bus.gnt_o, 0);
`ifdef AHB_PROTECTION_EN
        check("t1 parity", bus.m_hparity_o, 6'h32);
`else
        check("t1 parity", bus.m_hparity_o, 6'h00);
`endif
        cyc(); slv(1, 0, 32'hDEADBEEF); #1;
        check("t1 dp idle", bus.m_htrans_o, IDLE);
        check("t1 no rsp yet", bus.rsp_valid_o, 0);
        cyc(); slv(1, 0, 0); #1;
        check("t1 rsp", bus.rsp_valid_o, 1);
        check("t1 rdata", bus.rsp_rdata_o, 32'hDEADBEEF);
        check("t1 err", bus.rsp_err_o, 0);
        cyc(); #1;
        check("t1 rsp pulse", bus.rsp_valid_o, 0);

        // 2: back-to-back write then read, pipelined
        cyc(); req(1, 1, 2, 32'h10, 32'h11223344); #1;
        check("t2 gnt wr", bus.gnt_o, 1);
        cyc(); req(1, 0, 2, 32'h10, 32'h11223344); #1;
        check("t2 gnt rd", bus.gnt_o, 1);
        check("t2 ap wr", bus.m_htrans_o, NSQ);
        check("t2 hwrite1", bus.m_hwrite_o, 1);
        cyc(); req(0, 0, 0, 0, 0); #1;
        check("t2 ap rd", bus.m_htrans_o, NSQ);
        check("t2 hwrite0", bus.m_hwrite_o, 0);
        check("t2 hwdata", bus.m_hwdata_o, 32'h11223344);
        cyc(); slv(1, 0, 32'h11223344); #1;
        check("t2 rsp wr", bus.rsp_valid_o, 1);
        check("t2 rdata wr", bus.rsp_rdata_o, 0);
        check("t2 idle", bus.m_htrans_o, IDLE);
        cyc(); slv(1, 0, 0); #1;
        check("t2 rsp rd", bus.rsp_valid_o, 1);
        check("t2 rdata rd", bus.rsp_rdata_o, 32'h11223344);
        cyc(); #1;
        check("t2 rsp end", bus.rsp_valid_o, 0);

        // 3: two wait states with a third request pending
        cyc(); req(1, 1, 2, 32'h20, 32'hA5A5A5A5); #1;
        check("t3 gnt1", bus.gnt_o, 1);
        cyc(); req(1, 0, 2, 32'h24, 0); #1;
        check("t3 gnt2", bus.gnt_o, 1);
        check("t3 haddr1", bus.m_haddr_o, 32'h20);
        cyc(); req(1, 1, 2, 32'h28, 32'h5A5A5A5A); slv(0, 0, 0); #1;
        check("t3 w1 gnt", bus.gnt_o, 0);
        check("t3 w1 haddr", bus.m_haddr_o, 32'h24);
        check("t3 w1 hwdata", bus.m_hwdata_o, 32'hA5A5A5A5);
        check("t3 w1 htrans", bus.m_htrans_o, NSQ);
        cyc(); #1;
        check("t3 w2 gnt", bus.gnt_o, 0);
        check("t3 w2 haddr", bus.m_haddr_o, 32'h24);
        check("t3 w2 hwdata", bus.m_hwdata_o, 32'hA5A5A5A5);
        cyc(); slv(1, 0, 0); #1;
        check("t3 gnt3", bus.gnt_o, 1);
        check("t3 haddr hold", bus.m_haddr_o, 32'h24);
        check("t3 no rsp", bus.rsp_valid_o, 0);
        cyc(); req(0, 0, 0, 0, 0); slv(1, 0, 32'hCAFEF00D); #1;
        check("t3 rsp wr", bus.rsp_valid_o, 1);
        check("t3 rdata wr", bus.rsp_rdata_o, 0);
        check("t3 haddr3", bus.m_haddr_o, 32'h28);
        check("t3 hwrite3", bus.m_hwrite_o, 1);
        cyc(); slv(1, 0, 0); #1;
        check("t3 rsp rd", bus.rsp_valid_o, 1);
        check("t3 rdata rd", bus.rsp_rdata_o, 32'hCAFEF00D);
        check("t3 hwdata3", bus.m_hwdata_o, 32'h5A5A5A5A);
        cyc(); #1;
        check("t3 rsp wr3", bus.rsp_valid_o, 1);
        cyc(); #1;
        check("t3 rsp end", bus.rsp_valid_o, 0);

        // 4a: ERROR on first attempt, OK on retry
        cyc(); req(1, 0, 2, 32'h40, 0); #1;
        check("t4a gnt1", bus.gnt_o, 1);
        cyc(); req(1, 0, 2, 32'h44, 0); #1;
        check("t4a haddr", bus.m_haddr_o, 32'h40);
        cyc(); req(0, 0, 0, 0, 0); slv(0, 1, 0); #1;
        check("t4a err1 idle", bus.m_htrans_o, IDLE);
        check("t4a err1 gnt", bus.gnt_o, 0);
        cyc(); slv(1, 1, 0); #1;
        check("t4a err2 idle", bus.m_htrans_o, IDLE);
        check("t4a err2 rsp", bus.rsp_valid_o, 0);
        cyc(); slv(1, 0, 0); #1;
        check("t4a retry nsq", bus.m_htrans_o, NSQ);
        check("t4a retry addr", bus.m_haddr_o, 32'h40);
        cyc(); slv(1, 0, 32'h12345678); #1;
        check("t4a next nsq", bus.m_htrans_o, NSQ);
        check("t4a next addr", bus.m_haddr_o, 32'h44);
        check("t4a no rsp", bus.rsp_valid_o, 0);
        cyc(); slv(1, 0, 32'h9ABCDEF0); #1;
        check("t4a rsp1", bus.rsp_valid_o, 1);
        check("t4a rdata1", bus.rsp_rdata_o, 32'h12345678);
        check("t4a err1 flag", bus.rsp_err_o, 0);
        cyc(); slv(1, 0, 0); #1;
        check("t4a rsp2", bus.rsp_valid_o, 1);
        check("t4a rdata2", bus.rsp_rdata_o, 32'h9ABCDEF0);
        cyc(); #1;
        check("t4a rsp end", bus.rsp_valid_o, 0);

        // 4b: three consecutive ERRORs exhaust the retries
        cyc(); req(1, 0, 2, 32'h50, 0); #1;
        check("t4b gnt1", bus.gnt_o, 1);
        cyc(); req(1, 0, 2, 32'h54, 0); #1;
        check("t4b gnt2", bus.gnt_o, 1);
        cyc(); req(0, 0, 0, 0, 0); slv(0, 1, 0); #1;
        check("t4b a1 idle", bus.m_htrans_o, IDLE);
        cyc(); slv(1, 1, 0); #1;
        check("t4b a1 idle2", bus.m_htrans_o, IDLE);
        cyc(); slv(1, 0, 0); #1;
        check("t4b r1 addr", bus.m_haddr_o, 32'h50);
        check("t4b r1 nsq", bus.m_htrans_o, NSQ);
        cyc(); slv(0, 1, 0); #1;
        check("t4b a2 idle", bus.m_htrans_o, IDLE);
        cyc(); slv(1, 1, 0); #1;
        check("t4b a2 rsp", bus.rsp_valid_o, 0);
        cyc(); slv(1, 0, 0); #1;
        check("t4b r2 addr", bus.m_haddr_o, 32'h50);
        check("t4b r2 nsq", bus.m_htrans_o, NSQ);
        cyc(); slv(0, 1, 0); #1;
        check("t4b a3 idle", bus.m_htrans_o, IDLE);
        cyc(); slv(1, 1, 0); #1;
        check("t4b a3 rsp", bus.rsp_valid_o, 0);
        cyc(); slv(1, 0, 0); #1;
        check("t4b err rsp", bus.rsp_valid_o, 1);
        check("t4b err flag", bus.rsp_err_o, 1);
        check("t4b next nsq", bus.m_htrans_o, NSQ);
        check("t4b next addr", bus.m_haddr_o, 32'h54);
        cyc(); slv(1, 0, 32'h55AA55AA); #1;
        check("t4b gap", bus.rsp_valid_o, 0);
        cyc(); slv(1, 0, 0); #1;
        check("t4b rsp2", bus.rsp_valid_o, 1);
        check("t4b rdata2", bus.rsp_rdata_o, 32'h55AA55AA);
        check("t4b err2", bus.rsp_err_o, 0);

        // 5: parity / checksum generation and read-checksum checking
        cyc(); req(1, 1, 0, 32'h1, 32'h100); #1;
        check("t5 gnt wr", bus.gnt_o, 1);
        cyc(); req(0, 0, 0, 0, 0); #1;
        check("t5 nsq", bus.m_htrans_o, NSQ);
`ifdef AHB_PROTECTION_EN
        check("t5 parity", bus.m_hparity_o, 6'h31);
`else
        check("t5 parity", bus.m_hparity_o, 6'h00);
`endif
        cyc(); #1;
        check("t5 hwdata", bus.m_hwdata_o, 32'h100);
`ifdef AHB_PROTECTION_EN
        check("t5 wcks", bus.m_hwchecksum_o, 7'h49);
`else
        check("t5 wcks", bus.m_hwchecksum_o, 7'h00);
`endif
        cyc(); #1;
        check("t5 rsp wr", bus.rsp_valid_o, 1);
        cyc(); req(1, 0, 2, 32'h80, 0); #1;
        check("t5 gnt rd", bus.gnt_o, 1);
        cyc(); req(0, 0, 0, 0, 0); #1;
        check("t5 rd addr", bus.m_haddr_o, 32'h80);
        cyc(); bus.m_hready_i = 1; bus.m_hresp_i = 0;
        bus.m_hrdata_i = 32'h000000F0; bus.m_hrchecksum_i = 7'h0D; #1;
        cyc(); bus.m_hrchecksum_i = 7'h0C; #1;
`ifdef AHB_PROTECTION_EN
        check("t5 retry rsp", bus.rsp_valid_o, 0);
        check("t5 retry nsq", bus.m_htrans_o, NSQ);
        check("t5 retry addr", bus.m_haddr_o, 32'h80);
        cyc(); #1;
        check("t5 dp rsp", bus.rsp_valid_o, 0);
        cyc(); slv(1, 0, 0); #1;
`else
        slv(1, 0, 0);
`endif
        check("t5 rsp rd", bus.rsp_valid_o, 1);
        check("t5 rdata", bus.rsp_rdata_o, 32'h000000F0);
        check("t5 err", bus.rsp_err_o, 0);

        // 6: reset during an ERROR episode
        cyc(); req(1, 0, 2, 32'h90, 0); #1;
        check("t6 gnt", bus.gnt_o, 1);
        cyc(); req(0, 0, 0, 0, 0); #1;
        check("t6 haddr", bus.m_haddr_o, 32'h90);
        cyc(); slv(0, 1, 0); #1;
        check("t6 err idle", bus.m_htrans_o, IDLE);
        cyc(); #1;
        check("t6 held addr", bus.m_haddr_o, 32'h90);
        bus.req_i = 1'b1;
        #1 rstn = 1'b0;
        #1;
        check("t6 rst htrans", bus.m_htrans_o, IDLE);
        check("t6 rst haddr", bus.m_haddr_o, 0);
        check("t6 rst gnt", bus.gnt_o, 0);
        check("t6 rst rsp", bus.rsp_valid_o, 0);
        req(0, 0, 0, 0, 0);
        slv(1, 0, 0);
        @(negedge clk) rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc(); #1;
            if (bus.rsp_valid_o) rsp_cnt++;
        end
        check("t6 no rsp", rsp_cnt, 0);
        check("t6 idle", bus.m_htrans_o, IDLE);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
